// File: rtl/vec_math_pkg.sv
// Shared types and saturation helper for the fixed-point vector datapath cores.
package vec_math_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_DOT   = 3'd2,
      OP_CROSS = 3'd3,
      OP_SCALE = 3'd4
   } vec_op_t;

   localparam int unsigned VEC_LANES = 3;

   // Widest intermediate any core may hand to in_range().
   localparam int unsigned SAT_W = 128;

   // True when v is representable as a signed value of the given width.
   function automatic logic in_range(input logic signed [SAT_W-1:0] v,
                                     input int unsigned              bits);
      logic signed [SAT_W-1:0] t;
      t = v >>> (bits - 1);
      return (t == '0) || (t == '1);
   endfunction

endpackage

// File: rtl/vec_alu_pipe_if.sv
// Operand/result FIFO-side bus of the vector ALU; master is the ALU itself.
interface vec_alu_pipe_if #(
   parameter int unsigned D_BITS = 32
) ();

   logic [vec_math_pkg::VEC_LANES-1:0][D_BITS-1:0] x;
   logic [vec_math_pkg::VEC_LANES-1:0][D_BITS-1:0] y;
   logic [2:0]                                     op;
   logic                                           in_empty;
   logic                                           in_rd_en;
   logic [vec_math_pkg::VEC_LANES-1:0][D_BITS-1:0] out;
   logic                                           out_ovf;
   logic                                           out_full;
   logic                                           out_wr_en;

   modport master (
      input  x, y, op, in_empty, out_full,
      output in_rd_en, out, out_ovf, out_wr_en
   );

   modport slave (
      output x, y, op, in_empty, out_full,
      input  in_rd_en, out, out_ovf, out_wr_en
   );

endinterface

// File: rtl/vec_sat.sv
// Wide-to-narrow signed conversion: clamp or truncate, flagging out-of-range values.
module vec_sat
   import vec_math_pkg::*;
#(
   parameter int unsigned IN_BITS  = 66,
   parameter int unsigned OUT_BITS = 32,
   parameter bit          SAT      = 1'b1
) (
   input  logic signed [IN_BITS-1:0]  din,
   output logic        [OUT_BITS-1:0] dout,
   output logic                       ovf
);

   logic signed [SAT_W-1:0] ext;

   always_comb begin
      ext  = SAT_W'(din);
      ovf  = !in_range(ext, OUT_BITS);
      dout = din[OUT_BITS-1:0];
      if (SAT && ovf) begin
         dout = din[IN_BITS-1] ? {1'b1, {(OUT_BITS-1){1'b0}}}
                               : {1'b0, {(OUT_BITS-1){1'b1}}};
      end
   end

endmodule

// File: rtl/vec_alu_pipe.sv
// Two-stage fixed-point 3-vector ALU (add/sub/dot/cross/scale) between FWFT operand
// and result FIFOs, one transaction per clock with full backpressure.
module vec_alu_pipe
   import vec_math_pkg::*;
#(
   parameter int unsigned D_BITS = 32,
   parameter int unsigned Q_BITS = 16,
   parameter bit          SAT    = 1'b1
) (
   input logic            clock,
   input logic            reset,
   vec_alu_pipe_if.master bus
);

   localparam int unsigned P_BITS = 2 * D_BITS;
   localparam int unsigned W_BITS = 2 * D_BITS + 2;

   typedef logic [VEC_LANES-1:0][P_BITS-1:0] lanes_p_t;
   typedef logic [VEC_LANES-1:0][D_BITS-1:0] lanes_d_t;

   logic        v1_q, v2_q;
   logic [2:0]  op1_q;
   lanes_p_t    a1_q, b1_q, a1_d, b1_d;
   lanes_d_t    res2_q, res_d;
   logic        ovf2_q, ovf_d;
   logic        s1_load, s2_load, pop;

   logic signed [W_BITS-1:0] wide [VEC_LANES];
   logic [VEC_LANES-1:0]     lane_ovf;
   logic                     illegal;

   function automatic logic [P_BITS-1:0] mul(input logic [D_BITS-1:0] a,
                                             input logic [D_BITS-1:0] b);
      logic signed [P_BITS-1:0] pa, pb;
      pa = P_BITS'($signed(a));
      pb = P_BITS'($signed(b));
      return pa * pb;
   endfunction

   function automatic logic [P_BITS-1:0] sext(input logic [D_BITS-1:0] a);
      return P_BITS'($signed(a));
   endfunction

   function automatic logic signed [W_BITS-1:0] wext(input logic [P_BITS-1:0] v);
      return W_BITS'($signed(v));
   endfunction

   // Stage 1 operands: ADD/SUB carry the raw lanes, multiply ops carry full products.
   always_comb begin
      a1_d = '0;
      b1_d = '0;
      case (bus.op)
         OP_ADD, OP_SUB: begin
            for (int i = 0; i < VEC_LANES; i++) begin
               a1_d[i] = sext(bus.x[i]);
               b1_d[i] = sext(bus.y[i]);
            end
         end
         OP_DOT: begin
            for (int i = 0; i < VEC_LANES; i++) begin
               a1_d[i] = mul(bus.x[i], bus.y[i]);
            end
         end
         OP_CROSS: begin
            a1_d[0] = mul(bus.x[1], bus.y[2]);
            b1_d[0] = mul(bus.x[2], bus.y[1]);
            a1_d[1] = mul(bus.x[2], bus.y[0]);
            b1_d[1] = mul(bus.x[0], bus.y[2]);
            a1_d[2] = mul(bus.x[0], bus.y[1]);
            b1_d[2] = mul(bus.x[1], bus.y[0]);
         end
         OP_SCALE: begin
            for (int i = 0; i < VEC_LANES; i++) begin
               a1_d[i] = mul(bus.x[i], bus.y[0]);
            end
         end
         default: ;
      endcase
   end

   // Stage 2 wide results before narrowing; illegal opcodes leave every lane at zero.
   always_comb begin
      illegal = 1'b0;
      for (int i = 0; i < VEC_LANES; i++) begin
         wide[i] = '0;
      end
      case (op1_q)
         OP_ADD: begin
            for (int i = 0; i < VEC_LANES; i++) begin
               wide[i] = wext(a1_q[i]) + wext(b1_q[i]);
            end
         end
         OP_SUB: begin
            for (int i = 0; i < VEC_LANES; i++) begin
               wide[i] = wext(a1_q[i]) - wext(b1_q[i]);
            end
         end
         OP_DOT: begin
            wide[0] = (wext(a1_q[0]) >>> Q_BITS) + (wext(a1_q[1]) >>> Q_BITS)
                    + (wext(a1_q[2]) >>> Q_BITS);
         end
         OP_CROSS: begin
            for (int i = 0; i < VEC_LANES; i++) begin
               wide[i] = (wext(a1_q[i]) - wext(b1_q[i])) >>> Q_BITS;
            end
         end
         OP_SCALE: begin
            for (int i = 0; i < VEC_LANES; i++) begin
               wide[i] = wext(a1_q[i]) >>> Q_BITS;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

   for (genvar g = 0; g < VEC_LANES; g++) begin : g_lane
      vec_sat #(
         .IN_BITS (W_BITS),
         .OUT_BITS(D_BITS),
         .SAT     (SAT)
      ) u_sat (
         .din (wide[g]),
         .dout(res_d[g]),
         .ovf (lane_ovf[g])
      );
   end

   assign ovf_d = illegal | (|lane_ovf);

   assign s2_load       = !v2_q || !bus.out_full;
   assign s1_load       = !v1_q || s2_load;
   assign pop           = !bus.in_empty && s1_load;
   assign bus.in_rd_en  = pop;
   assign bus.out_wr_en = v2_q && !bus.out_full;
   assign bus.out       = res2_q;
   assign bus.out_ovf   = ovf2_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         op1_q  <= '0;
         a1_q   <= '0;
         b1_q   <= '0;
         res2_q <= '0;
         ovf2_q <= 1'b0;
      end else begin
         if (s1_load) begin
            v1_q <= pop;
            if (pop) begin
               op1_q <= bus.op;
               a1_q  <= a1_d;
               b1_q  <= b1_d;
            end
         end
         if (s2_load) begin
            v2_q <= v1_q;
            if (v1_q) begin
               res2_q <= res_d;
               ovf2_q <= ovf_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_vec_alu_pipe.sv
// Scoreboard bench for vec_alu_pipe: saturating and wrapping instances fed identical traffic.
module tb_vec_alu_pipe;
   import vec_math_pkg::*;

   typedef logic [2:0][31:0] vec_t;
   typedef struct {
      vec_t       x;
      vec_t       y;
      logic [2:0] op;
   } item_t;
   typedef struct {
      vec_t out_s;
      logic ovf_s;
      vec_t out_w;
      logic ovf_w;
      logic chk_lat;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   vec_t       x_drv, y_drv;
   logic [2:0] op_drv;
   logic       in_empty_drv, out_full_drv, hold_in;

   vec_alu_pipe_if #(.D_BITS(32)) bus_s ();
   vec_alu_pipe_if #(.D_BITS(32)) bus_w ();

   assign bus_s.x = x_drv;
   assign bus_s.y = y_drv;
   assign bus_s.op = op_drv;
   assign bus_s.in_empty = in_empty_drv;
   assign bus_s.out_full = out_full_drv;
   assign bus_w.x = x_drv;
   assign bus_w.y = y_drv;
   assign bus_w.op = op_drv;
   assign bus_w.in_empty = in_empty_drv;
   assign bus_w.out_full = out_full_drv;

   vec_alu_pipe #(.D_BITS(32), .Q_BITS(16), .SAT(1'b1)) dut_s (
      .clock(clock), .reset(reset), .bus(bus_s.master)
   );
   vec_alu_pipe #(.D_BITS(32), .Q_BITS(16), .SAT(1'b0)) dut_w (
      .clock(clock), .reset(reset), .bus(bus_w.master)
   );

   item_t       in_q[$];
   exp_t        exp_q[$];
   time         pop_t_q[$];
   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   int          out_n = 0;
   exp_t        e;
   time         t_pop;

   function automatic vec_t v3(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c);
      return {c, b, a};
   endfunction

   function automatic void chk(input string name, input logic [95:0] act,
                               input logic [95:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endfunction

   task automatic present();
      if (in_q.size() != 0) begin
         x_drv        = in_q[0].x;
         y_drv        = in_q[0].y;
         op_drv       = in_q[0].op;
         in_empty_drv = hold_in;
      end else begin
         x_drv        = '0;
         y_drv        = '0;
         op_drv       = '0;
         in_empty_drv = 1'b1;
      end
   endtask

   task automatic send(input logic [2:0] op, input vec_t x, input vec_t y,
                       input vec_t os, input logic vs, input vec_t ow, input logic vw,
                       input logic lat);
      item_t it;
      exp_t  ex;
      it.x = x; it.y = y; it.op = op;
      in_q.push_back(it);
      ex.out_s = os; ex.ovf_s = vs; ex.out_w = ow; ex.ovf_w = vw; ex.chk_lat = lat;
      exp_q.push_back(ex);
      present();
   endtask

   // Same expectation for both saturation modes.
   task automatic send1(input logic [2:0] op, input vec_t x, input vec_t y,
                        input vec_t o, input logic v, input logic lat);
      send(op, x, y, o, v, o, v, lat);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
         pop_t_q.delete();
      end
      step(1);
   endtask

   always @(posedge clock) begin
      #2;
      present();
   end

   // Input FIFO model and output monitor, both sampled mid-cycle.
   always @(negedge clock) begin
      if (!reset && bus_s.in_rd_en) begin
         if (in_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_empty: in_rd_en=1 with empty FIFO, required 0");
         end else begin
            void'(in_q.pop_front());
            pop_t_q.push_back($time);
            pops++;
         end
      end
      if (bus_s.out_wr_en || bus_w.out_wr_en) begin
         chk("wr_en_pair", 96'(bus_w.out_wr_en), 96'(bus_s.out_wr_en));
      end
      if (bus_s.out_wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_push: out=%h, required no push", bus_s.out);
         end else begin
            e     = exp_q.pop_front();
            t_pop = (pop_t_q.size() != 0) ? pop_t_q.pop_front() : 0;
            chk($sformatf("out_sat[%0d]", out_n), bus_s.out, e.out_s);
            chk($sformatf("ovf_sat[%0d]", out_n), 96'(bus_s.out_ovf), 96'(e.ovf_s));
            chk($sformatf("out_wrap[%0d]", out_n), bus_w.out, e.out_w);
            chk($sformatf("ovf_wrap[%0d]", out_n), 96'(bus_w.out_ovf), 96'(e.ovf_w));
            if (e.chk_lat) begin
               chk($sformatf("latency[%0d]", out_n), 96'($time - t_pop), 96'(20));
            end
            out_n++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t snap;
      int   p0, cnt;
      x_drv = '0; y_drv = '0; op_drv = '0;
      in_empty_drv = 1'b1; out_full_drv = 1'b0; hold_in = 1'b0;
      step(2);
      @(negedge clock);
      chk("rst_out", bus_s.out, '0);
      chk("rst_ovf", 96'(bus_s.out_ovf), '0);
      chk("rst_wr_en", 96'(bus_s.out_wr_en), '0);
      chk("rst_rd_en", 96'(bus_s.in_rd_en), '0);
      step(1);
      reset = 1'b0;

      // Directed vectors, back to back.
      send1(OP_ADD, v3(32'h18000, 0, 0), v3(32'h24000, 0, 0), v3(32'h3C000, 0, 0), 0, 1);
      send1(OP_DOT, v3(32'h10000, 32'h20000, 32'h30000), v3(32'h40000, 32'h50000, 32'h60000),
            v3(32'h200000, 0, 0), 0, 1);
      send1(OP_CROSS, v3(32'h10000, 0, 0), v3(0, 32'h10000, 0), v3(0, 0, 32'h10000), 0, 1);
      send1(OP_SCALE, v3(32'h10000, 32'hFFFE0000, 32'h8000), v3(32'h20000, 0, 0),
            v3(32'h20000, 32'hFFFC0000, 32'h10000), 0, 1);
      send1(3'd6, v3(32'h10000, 2, 3), v3(4, 5, 6), v3(0, 0, 0), 1, 1);
      send(OP_ADD, v3(32'h7FFF0000, 0, 0), v3(32'h20000, 0, 0),
           v3(32'h7FFFFFFF, 0, 0), 1, v3(32'h80010000, 0, 0), 1, 1);
      send(OP_SUB, v3(32'h80000000, 0, 0), v3(32'h10000, 0, 0),
           v3(32'h80000000, 0, 0), 1, v3(32'h7FFF0000, 0, 0), 1, 1);
      send1(OP_SUB, v3(32'h30000, 32'h10000, 32'hFFFF0000), v3(32'h10000, 32'h20000, 32'h10000),
            v3(32'h20000, 32'hFFFF0000, 32'hFFFE0000), 0, 1);
      send1(OP_DOT, v3(32'hFFFF8000, 0, 0), v3(32'h30000, 0, 0), v3(32'hFFFE8000, 0, 0), 0, 1);
      send1(OP_SCALE, v3(32'hFFFFFFFF, 1, 0), v3(32'h8000, 0, 0), v3(32'hFFFFFFFF, 0, 0), 0, 1);
      send(OP_DOT, v3(32'h7FFF0000, 32'h7FFF0000, 0), v3(32'h7FFF0000, 32'h7FFF0000, 0),
           v3(32'h7FFFFFFF, 0, 0), 1, v3(32'h00020000, 0, 0), 1, 1);
      send1(3'd7, v3(1, 1, 1), v3(1, 1, 1), v3(0, 0, 0), 1, 1);
      send1(OP_CROSS, v3(32'h10000, 32'h20000, 32'h30000), v3(32'h40000, 32'h50000, 32'h60000),
            v3(32'hFFFD0000, 32'h60000, 32'hFFFD0000), 0, 1);
      send1(OP_ADD, v3(32'h80000000, 32'h7FFFFFFF, 0), v3(0, 0, 0),
            v3(32'h80000000, 32'h7FFFFFFF, 0), 0, 1);
      drain(100);

      // Bubbles from a stuttering input FIFO.
      send1(OP_ADD, v3(1, 2, 3), v3(4, 5, 6), v3(5, 7, 9), 0, 1);
      send1(3'd5, v3(9, 9, 9), v3(9, 9, 9), v3(0, 0, 0), 1, 1);
      send1(OP_SCALE, v3(32'h10000, 32'h20000, 32'h30000), v3(32'h30000, 0, 0),
            v3(32'h30000, 32'h60000, 32'h90000), 0, 1);
      send1(OP_SUB, v3(0, 0, 0), v3(1, 1, 1), v3(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF), 0, 1);
      repeat (10) begin
         hold_in = ~hold_in;
         present();
         step(1);
      end
      hold_in = 1'b0;
      present();
      drain(100);

      // Backpressure: six queued, output FIFO full for five cycles.
      out_full_drv = 1'b1;
      p0 = pops;
      for (int i = 1; i <= 6; i++) begin
         send1(OP_ADD, v3(32'(i), 0, 32'(i)), v3(0, 32'(i), 0), v3(32'(i), 32'(i), 32'(i)), 0, 0);
      end
      step(3);
      @(negedge clock);
      snap = bus_s.out;
      step(2);
      chk("bp_pops", 96'(pops - p0), 96'(2));
      chk("bp_rd_en", 96'(bus_s.in_rd_en), '0);
      chk("bp_out_stable", bus_s.out, snap);
      out_full_drv = 1'b0;
      cnt = 0;
      repeat (6) begin
         @(negedge clock);
         if (bus_s.out_wr_en) cnt++;
      end
      chk("bp_back_to_back", 96'(cnt), 96'(6));
      drain(50);

      // Reset with both stages holding work.
      out_full_drv = 1'b1;
      send1(OP_ADD, v3(1, 1, 1), v3(1, 1, 1), v3(2, 2, 2), 0, 0);
      send1(OP_SUB, v3(3, 3, 3), v3(1, 1, 1), v3(2, 2, 2), 0, 0);
      step(3);
      reset = 1'b1;
      step(1);
      out_full_drv = 1'b0;
      @(negedge clock);
      chk("flush_wr_en", 96'(bus_s.out_wr_en), '0);
      chk("flush_wr_en_w", 96'(bus_w.out_wr_en), '0);
      chk("flush_out", bus_s.out, '0);
      chk("flush_ovf", 96'(bus_s.out_ovf), '0);
      chk("flush_rd_en", 96'(bus_s.in_rd_en), '0);
      exp_q.delete();
      pop_t_q.delete();
      step(1);
      reset = 1'b0;
      step(1);
      send1(OP_DOT, v3(32'h10000, 32'h10000, 32'h10000), v3(32'h20000, 32'h20000, 32'h20000),
            v3(32'h60000, 0, 0), 0, 1);
      drain(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
